// File: rtl/tl_rx_router.sv
`default_nettype none
// ============================================================================
// Module   : tl_rx_router
// Brief    : Receive-side TLP router. Classifies each TLP from header DW0,
//            steers its beats to the P/NP/Cpl queue and emits credit pulses.
// Revision : 1.0
// ============================================================================
module tl_rx_router #(
    parameter int STREAM_W   = 128,
    parameter int PD_WIDTH   = 12,
    parameter int NPD_WIDTH  = 12,
    parameter int CPLD_WIDTH = 12,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STREAM_W-1:0]   dl_rx_data_i,
    input  logic                  dl_rx_sop_i,
    input  logic                  dl_rx_eop_i,
    input  logic                  dl_rx_valid_i,
    output logic                  dl_rx_ready_o,
    output logic [STREAM_W-1:0]   p_data_o,
    output logic                  p_sop_o,
    output logic                  p_eop_o,
    output logic                  p_valid_o,
    input  logic                  p_ready_i,
    output logic [STREAM_W-1:0]   np_data_o,
    output logic                  np_sop_o,
    output logic                  np_eop_o,
    output logic                  np_valid_o,
    input  logic                  np_ready_i,
    output logic [STREAM_W-1:0]   cpl_data_o,
    output logic                  cpl_sop_o,
    output logic                  cpl_eop_o,
    output logic                  cpl_valid_o,
    input  logic                  cpl_ready_i,
    output logic                  ph_alloc_v_o,
    output logic                  nph_alloc_v_o,
    output logic                  cplh_alloc_v_o,
    output logic                  pd_alloc_v_o,
    output logic [PD_WIDTH-1:0]   pd_alloc_dw_o,
    output logic                  npd_alloc_v_o,
    output logic [NPD_WIDTH-1:0]  npd_alloc_dw_o,
    output logic                  cpld_alloc_v_o,
    output logic [CPLD_WIDTH-1:0] cpld_alloc_dw_o,
    output logic                  seq_err_o,
    output logic                  len_err_o,
    output logic [CNT_W-1:0]      drop_cnt_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2} state_t;

    localparam logic [1:0]  c_ROUTE_P   = 2'd0;
    localparam logic [1:0]  c_ROUTE_NP  = 2'd1;
    localparam logic [1:0]  c_ROUTE_CPL = 2'd2;
    localparam logic [10:0] c_CNT_MAX   = '1;

    state_t      r_state;
    logic [1:0]  r_route;
    logic [10:0] r_exp_beats;
    logic [10:0] r_beat_cnt;

    logic [4:0]  w_type;
    logic [9:0]  w_len;
    logic        w_has_data;
    logic        w_hdr4;
    logic [10:0] w_len_eff;
    logic [10:0] w_total_dw;
    logic [10:0] w_exp_beats;
    logic [10:0] w_data_dw;
    logic        w_is_p;
    logic        w_is_np;
    logic        w_is_cpl;
    logic        w_supported;
    logic [1:0]  w_sop_route;
    logic [1:0]  w_route;
    logic        w_q_ready;
    logic        w_ready;
    logic        w_hs;
    logic        w_fwd_beat;
    logic        w_sop_fwd;
    logic [10:0] w_cnt_nxt;

    // Header DW0 decode (only meaningful on a SOP beat)
    assign w_has_data  = dl_rx_data_i[STREAM_W-2];
    assign w_hdr4      = dl_rx_data_i[STREAM_W-3];
    assign w_type      = dl_rx_data_i[STREAM_W-4 -: 5];
    assign w_len       = dl_rx_data_i[STREAM_W-23 -: 10];
    assign w_len_eff   = (w_len == 10'd0) ? 11'd1024 : {1'b0, w_len};
    assign w_total_dw  = (w_hdr4 ? 11'd4 : 11'd3) + (w_has_data ? w_len_eff : 11'd0);
    assign w_exp_beats = (w_total_dw + 11'd3) >> 2;
    assign w_data_dw   = (w_len_eff + 11'd3) >> 2;

    assign w_is_p      = ((w_type == 5'b00000) && w_has_data) || (w_type[4:3] == 2'b10);
    assign w_is_np     = ((w_type == 5'b00000) && !w_has_data) || (w_type == 5'b00010) ||
                         (w_type[4:1] == 4'b0010);
    assign w_is_cpl    = (w_type == 5'b01010);
    assign w_supported = w_is_p || w_is_np || w_is_cpl;

    always_comb begin
        w_sop_route = c_ROUTE_P;
        if (w_is_np) begin
            w_sop_route = c_ROUTE_NP;
        end else if (w_is_cpl) begin
            w_sop_route = c_ROUTE_CPL;
        end
    end

    assign w_route = (r_state == FWD) ? r_route : w_sop_route;

    always_comb begin
        case (w_route)
            c_ROUTE_P:  w_q_ready = p_ready_i;
            c_ROUTE_NP: w_q_ready = np_ready_i;
            default:    w_q_ready = cpl_ready_i;
        endcase
    end

    // Ready follows the target queue only while a beat is being forwarded
    always_comb begin
        w_ready = 1'b1;
        if (rst) begin
            w_ready = 1'b0;
        end else begin
            case (r_state)
                IDLE:    w_ready = (dl_rx_sop_i && w_supported) ? w_q_ready : 1'b1;
                FWD:     w_ready = w_q_ready;
                default: w_ready = 1'b1;
            endcase
        end
    end

    assign dl_rx_ready_o = w_ready;
    assign w_hs          = dl_rx_valid_i && w_ready;
    assign w_fwd_beat    = dl_rx_valid_i && !rst &&
                           (((r_state == IDLE) && dl_rx_sop_i && w_supported) || (r_state == FWD));
    assign w_sop_fwd     = dl_rx_sop_i && (r_state != FWD);
    assign w_cnt_nxt     = (r_beat_cnt == c_CNT_MAX) ? r_beat_cnt : r_beat_cnt + 11'd1;

    assign p_data_o    = dl_rx_data_i;
    assign np_data_o   = dl_rx_data_i;
    assign cpl_data_o  = dl_rx_data_i;
    assign p_sop_o     = w_sop_fwd;
    assign np_sop_o    = w_sop_fwd;
    assign cpl_sop_o   = w_sop_fwd;
    assign p_eop_o     = dl_rx_eop_i;
    assign np_eop_o    = dl_rx_eop_i;
    assign cpl_eop_o   = dl_rx_eop_i;
    assign p_valid_o   = w_fwd_beat && (w_route == c_ROUTE_P);
    assign np_valid_o  = w_fwd_beat && (w_route == c_ROUTE_NP);
    assign cpl_valid_o = w_fwd_beat && (w_route == c_ROUTE_CPL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_route         <= c_ROUTE_P;
            r_exp_beats     <= '0;
            r_beat_cnt      <= '0;
            ph_alloc_v_o    <= 1'b0;
            nph_alloc_v_o   <= 1'b0;
            cplh_alloc_v_o  <= 1'b0;
            pd_alloc_v_o    <= 1'b0;
            npd_alloc_v_o   <= 1'b0;
            cpld_alloc_v_o  <= 1'b0;
            pd_alloc_dw_o   <= '0;
            npd_alloc_dw_o  <= '0;
            cpld_alloc_dw_o <= '0;
            seq_err_o       <= 1'b0;
            len_err_o       <= 1'b0;
            drop_cnt_o      <= '0;
        end else begin
            ph_alloc_v_o    <= 1'b0;
            nph_alloc_v_o   <= 1'b0;
            cplh_alloc_v_o  <= 1'b0;
            pd_alloc_v_o    <= 1'b0;
            npd_alloc_v_o   <= 1'b0;
            cpld_alloc_v_o  <= 1'b0;
            pd_alloc_dw_o   <= '0;
            npd_alloc_dw_o  <= '0;
            cpld_alloc_dw_o <= '0;
            seq_err_o       <= 1'b0;
            len_err_o       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        if (!dl_rx_sop_i) begin
                            seq_err_o <= 1'b1;
                        end else if (w_supported) begin
                            r_route     <= w_sop_route;
                            r_exp_beats <= w_exp_beats;
                            r_beat_cnt  <= 11'd1;
                            case (w_sop_route)
                                c_ROUTE_P: begin
                                    ph_alloc_v_o  <= 1'b1;
                                    pd_alloc_v_o  <= w_has_data;
                                    pd_alloc_dw_o <= w_has_data ? PD_WIDTH'(w_data_dw) : '0;
                                end
                                c_ROUTE_NP: begin
                                    nph_alloc_v_o  <= 1'b1;
                                    npd_alloc_v_o  <= w_has_data;
                                    npd_alloc_dw_o <= w_has_data ? NPD_WIDTH'(w_data_dw) : '0;
                                end
                                default: begin
                                    cplh_alloc_v_o  <= 1'b1;
                                    cpld_alloc_v_o  <= w_has_data;
                                    cpld_alloc_dw_o <= w_has_data ? CPLD_WIDTH'(w_data_dw) : '0;
                                end
                            endcase
                            if (dl_rx_eop_i) begin
                                len_err_o <= (w_exp_beats != 11'd1);
                            end else begin
                                r_state <= FWD;
                            end
                        end else begin
                            if (drop_cnt_o != '1) begin
                                drop_cnt_o <= drop_cnt_o + CNT_W'(1);
                            end
                            if (!dl_rx_eop_i) begin
                                r_state <= DROP;
                            end
                        end
                    end
                end
                FWD: begin
                    if (w_hs) begin
                        r_beat_cnt <= w_cnt_nxt;
                        seq_err_o  <= dl_rx_sop_i;
                        if (dl_rx_eop_i) begin
                            len_err_o <= (w_cnt_nxt != r_exp_beats);
                            r_state   <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (w_hs && dl_rx_eop_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
